windowed_frame_buffer: RTL

WINDOWED_FRAME_BUFFER -- requirements
Module: windowed_frame_buffer

---
 rtl/frame_pkg.sv | 18 +
 rtl/capture_dpram.sv | 36 +++
 rtl/windowed_frame_buffer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the windowed frame buffer.
//   state_e : capture controller states
//   mode_e  : capture mode encoding (continuous vs. single-shot)
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  typedef enum logic {
    MODE_CONT   = 1'b0,
    MODE_SINGLE = 1'b1
  } mode_e;

endpackage

// File: rtl/capture_dpram.sv
// Simple dual-port, dual-clock RAM with a registered read port.
//   wr_clk, wr_en, wr_addr, wr_data : write port (pixel clock domain)
//   rd_clk, rd_en, rd_addr, rd_data : read port; rd_data updates one rd_clk
//                                     after rd_en and holds otherwise
// Contents and rd_data are never reset.
module capture_dpram #(
  parameter int ADDR = 12,
  parameter int DATA = 10
) (
  input  logic            wr_clk,
  input  logic            wr_en,
  input  logic [ADDR-1:0] wr_addr,
  input  logic [DATA-1:0] wr_data,
  input  logic            rd_clk,
  input  logic            rd_en,
  input  logic [ADDR-1:0] rd_addr,
  output logic [DATA-1:0] rd_data
);

  logic [DATA-1:0] mem_r [0:(2**ADDR)-1];

  // Write port.
  always_ff @(posedge wr_clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds the last value when not enabled.
  always_ff @(posedge rd_clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/windowed_frame_buffer.sv
// Captures a rectangular window of a fv/lv pixel stream into a dual-clock RAM.
//   wr_clk, rst_n          : pixel clock and synchronous active-low reset
//   fv, lv, pix_data       : video input (registered once before use)
//   cfg_x0/y0/w/h          : window origin and size, latched at capture start
//   single_shot, arm       : capture mode and single-shot arm request
//   freeze                 : level; aborts capture and blocks writes
//   rd_clk, rd_en, rd_addr : read port (rd_clk domain)
//   rd_data                : registered read data
//   busy, frame_done       : status (WAIT_SOF/CAPTURE) and completion pulse
//   frame_len, overflow    : pixels in last completed frame; sticky overflow
module windowed_frame_buffer
  import frame_pkg::*;
#(
  parameter int DATA = 10,
  parameter int ADDR = 12,
  parameter int CW   = 11
) (
  input  logic            wr_clk,
  input  logic            rst_n,
  input  logic            rd_clk,
  input  logic            fv,
  input  logic            lv,
  input  logic [DATA-1:0] pix_data,
  input  logic [CW-1:0]   cfg_x0,
  input  logic [CW-1:0]   cfg_y0,
  input  logic [CW-1:0]   cfg_w,
  input  logic [CW-1:0]   cfg_h,
  input  logic            single_shot,
  input  logic            arm,
  input  logic            freeze,
  input  logic            rd_en,
  input  logic [ADDR-1:0] rd_addr,
  output logic [DATA-1:0] rd_data,
  output logic            busy,
  output logic            frame_done,
  output logic [ADDR:0]   frame_len,
  output logic            overflow
);

  // True when lo <= v < lo+len, evaluated one bit wider so lo+len cannot wrap.
  function automatic logic in_span(input logic [CW-1:0] v,
                                   input logic [CW-1:0] lo,
                                   input logic [CW-1:0] len);
    logic [CW:0] v_e;
    logic [CW:0] lo_e;
    logic [CW:0] hi_e;
    v_e  = {1'b0, v};
    lo_e = {1'b0, lo};
    hi_e = {1'b0, lo} + {1'b0, len};
    return (v_e >= lo_e) && (v_e < hi_e);
  endfunction

  logic            fv_r, fv_d_r, lv_r, lv_d_r;
  logic [DATA-1:0] pix_r;
  logic [CW-1:0]   col_r, row_r;
  logic [CW-1:0]   x0_r, y0_r, w_r, h_r;
  state_e          state_r, state_nx_s;
  logic [ADDR:0]   cnt_r;
  logic            wr_en_r;
  logic [ADDR-1:0] wr_addr_r;
  logic [DATA-1:0] wr_data_r;
  logic            busy_r, frame_done_r, overflow_r;
  logic [ADDR:0]   frame_len_r;

  logic            fv_rise_s, fv_fall_s, lv_rise_s, lv_fall_s;
  logic [CW-1:0]   col_s, row_s;
  logic [CW-1:0]   win_x0_s, win_y0_s, win_w_s, win_h_s;
  logic            start_s, cap_s, take_s, done_s, ram_we_s;
  logic [ADDR:0]   cnt_s;
  mode_e           mode_s;

  // Edge detection, current pixel coordinates and capture decisions.
  always_comb begin
    fv_rise_s = fv_r & ~fv_d_r;
    fv_fall_s = ~fv_r & fv_d_r;
    lv_rise_s = lv_r & ~lv_d_r;
    lv_fall_s = ~lv_r & lv_d_r;
    col_s     = lv_rise_s ? {CW{1'b0}} : col_r;
    row_s     = fv_rise_s ? {CW{1'b0}} : row_r;
    mode_s    = single_shot ? MODE_SINGLE : MODE_CONT;
    start_s   = (state_r == ST_WAIT_SOF) && fv_rise_s && !freeze;
    // On the start cycle the shadows are not loaded yet, so use cfg directly.
    win_x0_s  = start_s ? cfg_x0 : x0_r;
    win_y0_s  = start_s ? cfg_y0 : y0_r;
    win_w_s   = start_s ? cfg_w  : w_r;
    win_h_s   = start_s ? cfg_h  : h_r;
    cnt_s     = start_s ? {(ADDR+1){1'b0}} : cnt_r;
    cap_s     = ((state_r == ST_CAPTURE) || start_s) && !freeze && fv_r && lv_r;
    take_s    = cap_s && in_span(col_s, win_x0_s, win_w_s)
                      && in_span(row_s, win_y0_s, win_h_s);
    done_s    = (state_r == ST_CAPTURE) && fv_fall_s && !freeze;
    ram_we_s  = wr_en_r & ~freeze;
  end

  // Next-state logic of the capture controller; freeze overrides everything.
  always_comb begin
    state_nx_s = state_r;
    if (freeze) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if ((mode_s == MODE_CONT) || arm) begin
            state_nx_s = ST_WAIT_SOF;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_WAIT_SOF: begin
          if (fv_rise_s) begin
            state_nx_s = ST_CAPTURE;
          end else begin
            state_nx_s = ST_WAIT_SOF;
          end
        end
        ST_CAPTURE: begin
          if (fv_fall_s) begin
            state_nx_s = (mode_s == MODE_SINGLE) ? ST_DONE : ST_WAIT_SOF;
          end else begin
            state_nx_s = ST_CAPTURE;
          end
        end
        ST_DONE: begin
          if (arm) begin
            state_nx_s = ST_WAIT_SOF;
          end else begin
            state_nx_s = ST_DONE;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Input register stage. fv history resets high so that a frame already in
  // progress when reset releases is not mistaken for a start of frame.
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      fv_r   <= 1'b1;
      fv_d_r <= 1'b1;
      lv_r   <= 1'b0;
      lv_d_r <= 1'b0;
      pix_r  <= {DATA{1'b0}};
    end else begin
      fv_r   <= fv;
      fv_d_r <= fv_r;
      lv_r   <= lv;
      lv_d_r <= lv_r;
      pix_r  <= pix_data;
    end
  end

  // Column/row position counters.
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      col_r <= {CW{1'b0}};
      row_r <= {CW{1'b0}};
    end else begin
      if (lv_r) begin
        col_r <= col_s + CW'(1);
      end
      if (fv_rise_s) begin
        row_r <= {CW{1'b0}};
      end else if (lv_fall_s) begin
        row_r <= row_r + CW'(1);
      end
    end
  end

  // Controller state register.
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Window shadows, write address/count, write stage and overflow flag.
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      x0_r       <= {CW{1'b0}};
      y0_r       <= {CW{1'b0}};
      w_r        <= {CW{1'b0}};
      h_r        <= {CW{1'b0}};
      cnt_r      <= {(ADDR+1){1'b0}};
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADDR{1'b0}};
      wr_data_r  <= {DATA{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (start_s) begin
        x0_r <= cfg_x0;
        y0_r <= cfg_y0;
        w_r  <= cfg_w;
        h_r  <= cfg_h;
      end
      wr_addr_r <= cnt_s[ADDR-1:0];
      wr_data_r <= pix_r;
      // cnt == 2^ADDR is the only count with the top bit set: RAM is full.
      if (take_s && !cnt_s[ADDR]) begin
        wr_en_r <= 1'b1;
        cnt_r   <= cnt_s + (ADDR+1)'(1);
      end else begin
        wr_en_r <= 1'b0;
        cnt_r   <= cnt_s;
      end
      overflow_r <= (start_s ? 1'b0 : overflow_r) | (take_s & cnt_s[ADDR]);
    end
  end

  // Registered status outputs.
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      frame_len_r  <= {(ADDR+1){1'b0}};
    end else begin
      busy_r       <= (state_nx_s == ST_WAIT_SOF) || (state_nx_s == ST_CAPTURE);
      frame_done_r <= done_s;
      if (done_s) begin
        frame_len_r <= cnt_r;
      end
    end
  end

  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign frame_len  = frame_len_r;
  assign overflow   = overflow_r;

  capture_dpram #(
    .ADDR (ADDR),
    .DATA (DATA)
  ) u_ram (
    .wr_clk  (wr_clk),
    .wr_en   (ram_we_s),
    .wr_addr (wr_addr_r),
    .wr_data (wr_data_r),
    .rd_clk  (rd_clk),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
